// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer slice.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_WB         = 3'd4,
    ST_HALT       = 3'd5,
    ST_ERROR      = 3'd6
  } seq_state_e;

  // addi x0, x0, 0 -- filler instruction for benches and idle memories
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 32;

  // True in the states that make forward progress on an instruction
  function automatic logic is_active_state(seq_state_e s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
           (s == ST_EXEC) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-memory request/response channel between sequencer and memory.
interface core_seq_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, increment only while below all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the RV core datapath.
// Owns the fetch handshake, fetch timeout, halt and the perf counters.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  core_seq_ctrl_if.master  imem,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             wb_req,
  input  logic             stop,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  seq_state_e  state_q;
  seq_state_e  state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic        fetch_expired;
  logic        cycle_inc;
  logic        retire_inc;

  // Next-state, fetch timer, fetch address and instruction register updates
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    addr_d        = addr_q;
    inst_d        = inst_q;
    fetch_expired = (timer_q == TIMER_LAST);

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH_REQ;
        timer_d = '0;
        addr_d  = pc_in;
      end
      ST_FETCH_REQ: begin
        // A response cannot arrive before accept, so expiry here is fatal
        if (fetch_expired) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
          if (imem.req_ready) begin
            state_d = ST_FETCH_WAIT;
          end
        end
      end
      ST_FETCH_WAIT: begin
        // A response in the expiry cycle still completes the fetch
        if (imem.rsp_valid) begin
          inst_d  = imem.rsp_data;
          state_d = ST_EXEC;
        end else if (fetch_expired) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_EXEC: begin
        state_d = stop ? ST_HALT : ST_WB;
      end
      ST_WB: begin
        state_d = ST_FETCH_REQ;
        timer_d = '0;
        addr_d  = pc_in;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers, all returned to idle/zero by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  // Control outputs decoded from the current state only
  always_comb begin
    imem.req_valid = 1'b0;
    inst_valid     = 1'b0;
    pc_we          = 1'b0;
    rf_we          = 1'b0;
    halted         = 1'b0;
    fetch_err      = 1'b0;
    cycle_inc      = is_active_state(state_q);
    retire_inc     = 1'b0;

    unique case (state_q)
      ST_FETCH_REQ: imem.req_valid = 1'b1;
      ST_EXEC: begin
        inst_valid = 1'b1;
        retire_inc = stop;
      end
      ST_WB: begin
        pc_we      = 1'b1;
        rf_we      = wb_req;
        retire_inc = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      ST_ERROR: begin
        halted    = 1'b1;
        fetch_err = 1'b1;
      end
      default: begin
        imem.req_valid = 1'b0;
      end
    endcase
  end

  assign imem.req_addr = addr_q;
  assign inst          = inst_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cycle_inc),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_inc),
    .clr   (1'b0),
    .count (instret)
  );

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed scenarios plus a randomized
// run, checked per cycle against a transaction-level model of the sequencer.
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pc_in = '0;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             wb_req = 1'b0;
  logic             stop = 1'b0;
  logic             pc_we;
  logic             rf_we;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret;

  core_seq_ctrl_if imem ();

  core_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .imem       (imem),
    .inst       (inst),
    .inst_valid (inst_valid),
    .wb_req     (wb_req),
    .stop       (stop),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Reference model state: counts of active cycles and retirements so far,
  // the instruction most recently delivered, and the address of the
  // fetch currently being requested.
  int          active_cycles = 0;
  int          retired       = 0;
  logic [31:0] model_inst    = '0;
  logic [31:0] entry_pc      = '0;
  bit          ended_error;

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errs++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string ph, input bit req, input bit iv,
                          input bit pcwe, input bit rfwe, input bit hlt,
                          input bit err);
    checkOutput({ph, ".req_valid"},  32'(imem.req_valid), 32'(req));
    checkOutput({ph, ".inst_valid"}, 32'(inst_valid),     32'(iv));
    checkOutput({ph, ".pc_we"},      32'(pc_we),          32'(pcwe));
    checkOutput({ph, ".rf_we"},      32'(rf_we),          32'(rfwe));
    checkOutput({ph, ".halted"},     32'(halted),         32'(hlt));
    checkOutput({ph, ".fetch_err"},  32'(fetch_err),      32'(err));
    checkOutput({ph, ".inst"},       inst,                model_inst);
    checkOutput({ph, ".cycle_cnt"},  32'(cycle_cnt),      32'(sat(active_cycles)));
    checkOutput({ph, ".instret"},    32'(instret),        32'(sat(retired)));
  endtask

  task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rd,
                               input bit wb, input bit st);
    imem.req_ready = rdy;
    imem.rsp_valid = rv;
    imem.rsp_data  = rd;
    wb_req         = wb;
    stop           = st;
  endtask

  // Advance to just after the next rising edge, crediting the cycle that ended
  task automatic nextCycle(input bit was_active, input bit did_retire);
    @(posedge clk);
    #1;
    if (was_active) active_cycles++;
    if (did_retire) retired++;
  endtask

  // Asynchronous reset mid-cycle, hold, release; leaves the DUT in FETCH_REQ
  task automatic doReset(input bit junk_rsp, input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    active_cycles = 0;
    retired       = 0;
    model_inst    = '0;
    checkAll("reset_async", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
      @(negedge clk);
      checkAll("reset_hold", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    pc_in = pc;
    applyStimulus(1'b1, junk_rsp, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("idle", 0, 0, 0, 0, 0, 0);
    entry_pc = pc_in;
    nextCycle(1'b0, 1'b0);
  endtask

  // One instruction from its first FETCH_REQ cycle: rdy_delay cycles of
  // backpressure, response rsp_lat cycles after accept, then EXEC and WB.
  task automatic runInst(input int rdy_delay, input int rsp_lat,
                         input logic [31:0] data, input bit wb, input bit stp,
                         output bit timed_out);
    int n;
    bit responded;
    n = 0;
    responded = 1'b0;
    timed_out = 1'b0;
    for (int k = 0; k <= rdy_delay; k++) begin
      n++;
      applyStimulus(k == rdy_delay, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      checkAll("fetch_req", 1, 0, 0, 0, 0, 0);
      checkOutput("fetch_req.addr", imem.req_addr, entry_pc);
      nextCycle(1'b1, 1'b0);
      if (n == TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (!timed_out) begin
      for (int j = 1; j <= rsp_lat; j++) begin
        n++;
        applyStimulus(1'($urandom), j == rsp_lat, data, 1'($urandom), 1'($urandom));
        @(negedge clk);
        checkAll("fetch_wait", 0, 0, 0, 0, 0, 0);
        nextCycle(1'b1, 1'b0);
        if (j == rsp_lat) begin
          model_inst = data;
          responded  = 1'b1;
          break;
        end
        if (n == TIMEOUT) begin
          timed_out = 1'b1;
          break;
        end
      end
    end
    if (responded) begin
      pc_in = $urandom;
      applyStimulus(1'($urandom), 1'($urandom), $urandom, wb, stp);
      @(negedge clk);
      checkAll("exec", 0, 1, 0, 0, 0, 0);
      nextCycle(1'b1, stp);
      if (!stp) begin
        applyStimulus(1'($urandom), 1'($urandom), $urandom, wb, 1'($urandom));
        @(negedge clk);
        checkAll("wb", 0, 0, 1, wb, 0, 0);
        entry_pc = pc_in;
        nextCycle(1'b1, 1'b1);
      end
    end
  endtask

  // Terminal states: flags sticky, no requests, counters frozen
  task automatic checkTerminal(input string ph, input bit err, input int ncycles);
    for (int i = 0; i < ncycles; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      checkAll(ph, 0, 0, 0, 0, 1, err);
      nextCycle(1'b0, 1'b0);
    end
  endtask

  initial begin
    $display("[TB] core_seq_ctrl bench start, TIMEOUT=%0d CNT_W=%0d", TIMEOUT, CNT_W);
    applyStimulus(1'b0, 1'b0, NOP_INST, 1'b0, 1'b0);

    // Reset, then a single instruction with an always-ready, 1-cycle memory
    doReset(1'b0, 32'h8000_0000);
    runInst(0, 1, 32'h0010_0093, 1'b1, 1'b0, ended_error);

    // Backpressure on the request, no register write
    runInst(3, 1, 32'h0020_8133, 1'b0, 1'b0, ended_error);
    runInst(1, 3, NOP_INST, 1'b1, 1'b0, ended_error);

    // Reset while waiting for a response; late response after release is dropped
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("pre_reset_req", 1, 0, 0, 0, 0, 0);
    nextCycle(1'b1, 1'b0);
    doReset(1'b1, 32'h0000_1000);
    runInst(0, 2, 32'h00A0_0513, 1'b1, 1'b0, ended_error);

    // ebreak: halts after EXEC, retires once, never requests again
    runInst(0, 1, 32'h0010_0073, 1'b0, 1'b1, ended_error);
    checkTerminal("halt", 1'b0, 20);

    // Memory never answers: error after TIMEOUT fetch cycles
    doReset(1'b0, 32'h0000_2000);
    runInst(0, 1000, 32'h1234_5678, 1'b1, 1'b0, ended_error);
    checkOutput("timeout.flagged", 32'(ended_error), 32'd1);
    checkTerminal("error", 1'b1, 10);

    // Response exactly in the expiry cycle still completes
    doReset(1'b0, 32'h0000_3000);
    runInst(0, TIMEOUT - 1, 32'h0030_0193, 1'b1, 1'b0, ended_error);
    checkOutput("expiry_rsp.no_error", 32'(ended_error), 32'd0);

    // Randomized run long enough to saturate cycle_cnt
    for (int i = 0; i < 70; i++) begin
      runInst($urandom_range(3, 0), $urandom_range(3, 1), $urandom,
              1'($urandom), 1'b0, ended_error);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the RV core datapath (IFU / IDU / EXU). It issues instruction fetches to instruction memory over a valid/ready request channel and waits for the response. It then latches the instruction and drives it to decode/execute, and commits the result by pulsing PC-update and register-write enables. It also owns halt (stop from decode), the fetch-timeout error, and the cycle and retired-instruction counters.

Parameters:
TIMEOUT, 255, max cycles spent in FETCH_REQ+FETCH_WAIT for one fetch before declaring fetch error (>=2)
CNT_W, 32, width of cycle_cnt and instret counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset (0 = reset)
pc_in  in  32  current PC from IFU
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction
inst  out  32  instruction register to IDU
inst_valid  out  1  inst is being executed this cycle
wb_req  in  1  IDU: current inst writes rd
stop  in  1  IDU: current inst halts simulation (ebreak)
pc_we  out  1  IFU PC-advance pulse
rf_we  out  1  register-file write pulse
halted  out  1  sticky: core stopped by stop
fetch_err  out  1  sticky: fetch timed out
cycle_cnt  out  CNT_W  active cycles
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 (inst=0, counters=0); timeout counter=0. Effect is immediate, independent of clk.
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT, ERROR.
- IDLE: first clk edge with rst=1 -> FETCH_REQ.
- FETCH_REQ: imem_req_valid=1, imem_req_addr=pc_in (registered on entry, held stable until accepted). Valid is never withdrawn before ready. valid&ready -> FETCH_WAIT. imem_rsp_valid in this state is ignored.
- FETCH_WAIT: imem_rsp_valid=1 -> latch imem_rsp_data into inst, go to EXEC. Memory response latency >=1 cycle after accept.
- Timeout: counter clears on entering FETCH_REQ and increments every cycle in FETCH_REQ/FETCH_WAIT. When it reaches TIMEOUT-1 without a response -> ERROR. A response in the same cycle as expiry wins (-> EXEC).
- EXEC: inst_valid=1 for exactly one cycle. Sample stop: stop=1 -> HALT, instret+1, no pc_we/rf_we. Otherwise -> WB.
- WB: pc_we=1, rf_we=wb_req (one-cycle pulses), instret+1, -> FETCH_REQ.
- Throughput: 4 cycles/instruction with a ready-always, 1-cycle-latency memory.
- HALT: halted=1 sticky; ERROR: fetch_err=1 and halted=1 sticky. Both are terminal until reset; no requests issued.
- cycle_cnt increments each cycle in FETCH_REQ..WB. instret and cycle_cnt saturate at 2^CNT_W-1 (no wrap).
- Outputs other than imem_req_addr, inst and counters are decoded from state (Moore). inst holds its value until the next fetch completes.
- Reset mid-operation: any in-flight response arriving after reset lands in IDLE/FETCH_REQ and is dropped.

Decomposition:
- Package core_seq_pkg: state enum (3-bit), NOP_INST=32'h0000_0013 constant (bench filler), default TIMEOUT/CNT_W localparams.
- Sub-module sat_counter (param W; inputs inc, clr; async active-low reset), instantiated for cycle_cnt and instret.

Test Plan:
- Reset: hold rst=0, toggle clk -> all outputs 0; assert rst=0 asynchronously mid-cycle -> outputs 0 before next edge.
- Single inst, ready=1, 1-cycle latency, pc_in=0x8000_0000, rsp 0x0010_0093, wb_req=1 -> req_valid cycle1 with addr 0x8000_0000. EXEC cycle3 with inst=0x0010_0093. pc_we=rf_we=1 cycle4. instret=1. Next req cycle5.
- Backpressure: ready=0 for 3 cycles -> req_valid held 4 cycles, addr stable, then accept; rf_we=0 when wb_req=0.
- Stop: rsp 0x0010_0073 with stop=1 in EXEC -> halted=1 next cycle, no pc_we/rf_we, instret=1, req_valid stays 0 for 20 cycles.
- Timeout: TIMEOUT=8, never respond -> fetch_err=halted=1 after 8 fetch cycles. Rerun with rsp on cycle 8 -> EXEC, no error.
- Reset in FETCH_WAIT, then rsp_valid pulse right after release -> pulse ignored, fresh request issued, inst=0.
